// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared pipeline constants and types for the hazard scoreboard
// Contents: register count, register-index type, per-class forwarding wait constants.
package hazard_scoreboard_pkg;

  localparam int NREG  = 32;
  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  // Cycles until a result is reachable by forwarding, per producer class.
  localparam int LOAD_EXE_WAIT = 1;
  localparam int LOAD_ID_WAIT  = 2;
  localparam int ALU_EXE_WAIT  = 0;
  localparam int ALU_ID_WAIT   = 1;

endpackage

// File: rtl/hazard_scoreboard_wait_counter.sv
// rtl/hazard_scoreboard_wait_counter.sv - loadable down-counter that saturates at zero
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   load, load_val load a new wait value (takes priority over decrement)
//   dec_en         decrement by one when non-zero
//   count          current wait value
module wait_counter
  import hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec_en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec_en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - register-write scoreboard that stalls ID on unforwardable operands
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid                   ID holds a real instruction
//   id_rs, id_rt               source register numbers
//   id_use_rs, id_use_rt       instruction reads rs / rt
//   id_is_branch               operands needed in ID rather than EXE
//   id_regwrite, id_is_load    destination write and producer class
//   id_dest                    destination register
//   ext_hold                   global freeze
//   stall, bubble              hold PC/IF-ID and zero ID/EXE control
//   pending                    per-register outstanding-write flags
//   stall_cycles               saturating stall-cycle count
module hazard_scoreboard #(
  parameter int NREG   = hazard_scoreboard_pkg::NREG,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_is_branch,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  input  logic [4:0]        id_dest,
  input  logic              ext_hold,
  output logic              stall,
  output logic              bubble,
  output logic [NREG-1:0]   pending,
  output logic [PERF_W-1:0] stall_cycles
);

  import hazard_scoreboard_pkg::*;

  logic [CNT_W-1:0]  exe_wait [NREG];
  logic [CNT_W-1:0]  id_wait  [NREG];
  logic [CNT_W-1:0]  wait_rs;
  logic [CNT_W-1:0]  wait_rt;
  logic [CNT_W-1:0]  exe_ld_val;
  logic [CNT_W-1:0]  id_ld_val;
  logic              issue;
  logic              wr_en;
  logic              dec_en;
  logic [PERF_W-1:0] stall_cycles_d;
  logic [PERF_W-1:0] stall_cycles_q;

  // Branches consume in ID, so they see the longer ID-side wait.
  always_comb begin
    wait_rs = id_is_branch ? id_wait[id_rs] : exe_wait[id_rs];
    wait_rt = id_is_branch ? id_wait[id_rt] : exe_wait[id_rt];
  end

  assign stall  = id_valid & ~ext_hold &
                  ((id_use_rs & (wait_rs != '0)) | (id_use_rt & (wait_rt != '0)));
  assign bubble = stall;
  assign issue  = id_valid & ~stall & ~ext_hold;
  assign wr_en  = issue & id_regwrite & (id_dest != '0);
  assign dec_en = ~ext_hold;

  assign exe_ld_val = id_is_load ? CNT_W'(LOAD_EXE_WAIT) : CNT_W'(ALU_EXE_WAIT);
  assign id_ld_val  = id_is_load ? CNT_W'(LOAD_ID_WAIT)  : CNT_W'(ALU_ID_WAIT);

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    if (r == 0) begin : g_zero
      // Register 0 is hard-wired zero: never pending, never stalls.
      assign exe_wait[r] = '0;
      assign id_wait[r]  = '0;
    end else begin : g_cnt
      logic ld;
      assign ld = wr_en & (id_dest == 5'(r));

      wait_counter #(.CNT_W(CNT_W)) u_exe_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ld),
        .load_val (exe_ld_val),
        .dec_en   (dec_en),
        .count    (exe_wait[r])
      );

      wait_counter #(.CNT_W(CNT_W)) u_id_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ld),
        .load_val (id_ld_val),
        .dec_en   (dec_en),
        .count    (id_wait[r])
      );
    end
    assign pending[r] = (exe_wait[r] != '0) | (id_wait[r] != '0);
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_use_rs, id_use_rt, id_is_branch, id_regwrite, id_is_load, ext_hold;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        stall, bubble, s_stall, s_bubble;
  logic [31:0] pending, s_pending;
  logic [15:0] stall_cycles;
  logic [3:0]  s_stall_cycles;

  int cmp_cnt = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_branch(id_is_branch),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_dest(id_dest),
    .ext_hold(ext_hold), .stall(stall), .bubble(bubble), .pending(pending),
    .stall_cycles(stall_cycles)
  );

  // Narrow perf counter so saturation is reachable in a short run.
  hazard_scoreboard #(.PERF_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_branch(id_is_branch),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_dest(id_dest),
    .ext_hold(ext_hold), .stall(s_stall), .bubble(s_bubble), .pending(s_pending),
    .stall_cycles(s_stall_cycles)
  );

  typedef struct {
    logic        v, urs, urt, br, rw, ld, hold;
    logic [4:0]  rs, rt, dest;
    logic        exp_stall;
    logic [31:0] exp_pend;
    logic [15:0] exp_sc;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                              logic br, logic rw, logic ld, logic [4:0] dest, logic hold,
                              logic est, logic [31:0] epend, logic [15:0] esc);
    vec_t t;
    t.v = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt; t.br = br;
    t.rw = rw; t.ld = ld; t.dest = dest; t.hold = hold;
    t.exp_stall = est; t.exp_pend = epend; t.exp_sc = esc;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.v; id_rs = t.rs; id_rt = t.rt; id_use_rs = t.urs; id_use_rt = t.urt;
    id_is_branch = t.br; id_regwrite = t.rw; id_is_load = t.ld; id_dest = t.dest;
    ext_hold = t.hold;
  endtask

  // Drive at negedge, check stall before the edge, check state after it.
  task automatic step(input vec_t t, input int idx);
    @(negedge clk);
    drive(t);
    #1;
    chk($sformatf("v%0d stall", idx), 32'(stall), 32'(t.exp_stall));
    chk($sformatf("v%0d bubble", idx), 32'(bubble), 32'(t.exp_stall));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d pending", idx), pending, t.exp_pend);
    chk($sformatf("v%0d stall_cycles", idx), 32'(stall_cycles), 32'(t.exp_sc));
  endtask

  initial begin
    vec_t lw8, beq8, nop;
    //             v rs rt urs urt br rw ld dest hold  st pend        sc
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 8, 0,  0, 32'h100, 1'b0)); // lw $8
    vecs.push_back(mk(1, 8, 0, 1, 0, 0, 1, 0,10, 0,  1, 32'h100, 1));    // add rs=8: 1 stall
    vecs.push_back(mk(1, 8, 0, 1, 0, 0, 1, 0,10, 0,  0, 32'h400, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,   1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 8, 0,  0, 32'h100, 1));    // lw $8
    vecs.push_back(mk(1, 8, 0, 1, 0, 1, 0, 0, 0, 0,  1, 32'h100, 2));    // beq rs=8: 2 stalls
    vecs.push_back(mk(1, 8, 0, 1, 0, 1, 0, 0, 0, 0,  1, 32'h0,   3));
    vecs.push_back(mk(1, 8, 0, 1, 0, 1, 0, 0, 0, 0,  0, 32'h0,   3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 5, 0,  0, 32'h20,  3));    // add $5
    vecs.push_back(mk(1, 0, 5, 0, 1, 1, 0, 0, 0, 0,  1, 32'h0,   4));    // beq rt=5: 1 stall
    vecs.push_back(mk(1, 0, 5, 0, 1, 1, 0, 0, 0, 0,  0, 32'h0,   4));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 5, 0,  0, 32'h20,  4));    // add $5
    vecs.push_back(mk(1, 0, 5, 0, 1, 0, 1, 0, 6, 0,  0, 32'h40,  4));    // ALU reader: 0 stalls
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,   4));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0,  0, 32'h0,   4));    // lw $0: no entry
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 1, 0, 0, 0,  0, 32'h0,   4));    // reads $0
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 9, 0,  0, 32'h200, 4));    // lw $9
    vecs.push_back(mk(1, 9, 0, 1, 0, 0, 1, 0,10, 1,  0, 32'h200, 4));    // held x3
    vecs.push_back(mk(1, 9, 0, 1, 0, 0, 1, 0,10, 1,  0, 32'h200, 4));
    vecs.push_back(mk(1, 9, 0, 1, 0, 0, 1, 0,10, 1,  0, 32'h200, 4));
    vecs.push_back(mk(1, 9, 0, 1, 0, 0, 1, 0,10, 0,  1, 32'h200, 5));    // release: 1 stall
    vecs.push_back(mk(1, 9, 0, 1, 0, 0, 1, 0,10, 0,  0, 32'h400, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,   5));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 7, 0,  0, 32'h80,  5));    // lw $7
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 7, 0,  0, 32'h80,  5));    // add $7 overwrites
    vecs.push_back(mk(1, 7, 0, 1, 0, 1, 0, 0, 0, 0,  1, 32'h0,   6));    // id_wait[7]=1
    vecs.push_back(mk(1, 7, 0, 1, 0, 1, 0, 0, 0, 0,  0, 32'h0,   6));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 7, 0,  0, 32'h80,  6));    // lw $7
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 7, 0,  0, 32'h80,  6));    // lw $7 reloads
    vecs.push_back(mk(1, 7, 0, 1, 0, 0, 1, 0, 0, 0,  1, 32'h80,  7));    // exe_wait[7]=1
    vecs.push_back(mk(1, 7, 0, 1, 0, 0, 1, 0, 0, 0,  0, 32'h0,   7));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1,12, 0,  0, 32'h0,   7));    // regwrite=0
    vecs.push_back(mk(1,12, 0, 1, 0, 1, 0, 0, 0, 0,  0, 32'h0,   7));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 3, 0,  0, 32'h8,   7));    // lw $3
    vecs.push_back(mk(0, 3, 0, 1, 0, 1, 0, 0, 0, 0,  0, 32'h8,   7));    // not valid
    vecs.push_back(mk(1, 3, 0, 0, 0, 1, 0, 0, 0, 0,  0, 32'h0,   7));    // rs not used

    nop  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lw8  = mk(1, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0, 0);
    beq8 = mk(1, 8, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    rst_n = 1'b0;
    drive(nop);
    #12;
    chk("reset stall", 32'(stall), 0);
    chk("reset pending", pending, 0);
    chk("reset stall_cycles", 32'(stall_cycles), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], i);
    end

    // Asynchronous reset in the middle of a load->branch stall.
    @(negedge clk);
    drive(lw8);
    @(negedge clk);
    drive(beq8);
    #1;
    chk("pre-reset stall", 32'(stall), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst stall", 32'(stall), 0);
    chk("async rst bubble", 32'(bubble), 0);
    chk("async rst pending", pending, 0);
    chk("async rst stall_cycles", 32'(stall_cycles), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset stall", 32'(stall), 0);
    @(negedge clk);
    drive(lw8);
    @(posedge clk);
    #1;
    chk("post-reset first edge pending", pending, 32'h100);
    chk("post-reset stall_cycles", 32'(stall_cycles), 0);

    // Saturation: 2 stalls per iteration; 4-bit counter must stick at 15.
    for (int it = 0; it < 10; it++) begin
      @(negedge clk);
      drive(lw8);
      #1;
      chk($sformatf("sat it%0d lw stall", it), 32'(stall), 0);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        drive(beq8);
        #1;
        chk($sformatf("sat it%0d beq%0d stall", it, k), 32'(stall), (k < 2) ? 1 : 0);
      end
      if (it == 6) begin
        @(posedge clk);
        #1;
        chk("sat counter at 14", 32'(s_stall_cycles), 14);
      end
    end
    @(negedge clk);
    drive(nop);
    @(posedge clk);
    #1;
    chk("main stall_cycles after 20", 32'(stall_cycles), 20);
    chk("narrow stall_cycles saturated", 32'(s_stall_cycles), 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
